// File: rtl/i2c_fnd_pkg.sv
// ----------------------------------------------------------------------------
// i2c_fnd_pkg
// Shared definitions for the multiplexed I2C 7-segment slave:
//   state_t      - 4-bit FSM state encoding (also exported on debug_state)
//   FND_BLANK    - stored digit code that lights no segment
//   ptr_width()  - register pointer / digit index width for a digit count
//   seg_decode() - hex glyph to active-low {g..a} segment pattern
// ----------------------------------------------------------------------------
package i2c_fnd_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RX_ADDR   = 4'd1,
        ADDR_ACK  = 4'd2,
        RX_PTR    = 4'd3,
        PTR_ACK   = 4'd4,
        RX_DATA   = 4'd5,
        DATA_ACK  = 4'd6,
        TX_DATA   = 4'd7,
        TX_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    // Bit 7 set means "blank"; the low nibble is then irrelevant.
    localparam logic [7:0] FND_BLANK = 8'h80;

    // A single-digit display still needs a 1-bit pointer so that vectors
    // never collapse to zero width.
    function automatic int ptr_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

    // Common-anode glyph table, segments ordered {g,f,e,d,c,b,a}, 0 = lit.
    function automatic logic [6:0] seg_decode(input logic blank, input logic [3:0] hex);
        logic [6:0] seg;
        seg = 7'h7F;
        if (!blank) begin
            case (hex)
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                4'hF: seg = 7'b0001110;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan_driver.sv
// ----------------------------------------------------------------------------
// fnd_scan_driver
// Time-multiplexes NUM_DIGITS committed digit codes onto one shared segment
// bus. Each digit is lit for SCAN_DIV clk cycles, then the index advances.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   display    - committed digit codes (bit7 = blank, bits[3:0] = hex)
//   seg        - active-low segment cathodes {g..a}
//   an         - active-low one-hot digit anodes
// AN and SEG are both registered from the same next-index value so they
// always change together; SEG follows a display change one clk later.
// ----------------------------------------------------------------------------
module fnd_scan_driver
    import i2c_fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            display [NUM_DIGITS],
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int PTR_W = ptr_width(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]      cnt_reg;
    logic [PTR_W-1:0]      idx_reg;
    logic [PTR_W-1:0]      idx_next;
    logic                  cnt_wrap;
    logic [6:0]            seg_reg;
    logic [NUM_DIGITS-1:0] an_reg;

    // Bits 6:4 of a digit code carry no glyph information.
    logic [NUM_DIGITS-1:0] unused_hi;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unused
            assign unused_hi[gi] = ^display[gi][6:4];
        end
    endgenerate

    assign cnt_wrap = (cnt_reg == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx_reg;
        if (cnt_wrap) begin
            idx_next = (idx_reg == PTR_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + PTR_W'(1);
        end
    end

    // Free-running: nothing on the I2C side can stall the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            seg_reg <= 7'h7F;
            an_reg  <= ~NUM_DIGITS'(1);
        end else begin
            cnt_reg <= cnt_wrap ? '0 : cnt_reg + CNT_W'(1);
            idx_reg <= idx_next;
            seg_reg <= seg_decode(display[idx_next][7], display[idx_next][3:0]);
            an_reg  <= ~(NUM_DIGITS'(1) << idx_next);
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: rtl/i2c_fnd_mux_slave.sv
// ----------------------------------------------------------------------------
// i2c_fnd_mux_slave
// I2C slave that receives [ADDR,W][PTR][D0][D1]... into a staging buffer and
// copies the whole buffer to the displayed digits at STOP (only if at least
// one data byte was accepted). The pointer auto-increments modulo
// NUM_DIGITS. A repeated START or reset discards the pending commit.
//
// Optional feature macro: FND_SLAVE_READBACK_EN
//   defined   - a read address is ACKed and display[ptr] (committed values)
//               is shifted out, ptr auto-incrementing, until master NACK
//   undefined - a read address is NACKed and no transmit logic exists
//
// Parameters: SLAVE_ADDR (7-bit), NUM_DIGITS (1..8), SCAN_DIV (>=2)
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   scl               - I2C clock from master
//   sda               - I2C data, open drain (drives 0 or releases)
//   SEG               - active-low segments {g..a}
//   AN                - active-low one-hot digit anodes
//   debug_addr_match  - current transaction addressed this slave
//   debug_state       - FSM state encoding
// ----------------------------------------------------------------------------
module i2c_fnd_mux_slave
    import i2c_fnd_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h56,
    parameter int         NUM_DIGITS = 4,
    parameter int         SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [6:0]            SEG,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  debug_addr_match,
    output logic [3:0]            debug_state
);

    localparam int         PTR_W      = ptr_width(NUM_DIGITS);
    localparam logic [7:0] NUM_DIG_B  = 8'(NUM_DIGITS);

    // ---------------------------------------------------------------------
    // Bus synchroniser and event detection. Index 0 is the newest sample;
    // events compare stages 1 and 2 so they act on the third clk edge.
    // ---------------------------------------------------------------------
    logic [2:0] scl_sync_reg;
    logic [2:0] sda_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_reg <= 3'b111;
            sda_sync_reg <= 3'b111;
        end else begin
            scl_sync_reg <= {scl_sync_reg[1:0], scl};
            sda_sync_reg <= {sda_sync_reg[1:0], sda};
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic scl_high;
    logic sda_bit;
    logic start_det;
    logic stop_det;

    assign scl_rise  =  scl_sync_reg[1] & ~scl_sync_reg[2];
    assign scl_fall  = ~scl_sync_reg[1] &  scl_sync_reg[2];
    assign scl_high  =  scl_sync_reg[1] &  scl_sync_reg[2];
    assign sda_bit   =  sda_sync_reg[1];
    assign start_det =  scl_high & ~sda_sync_reg[1] &  sda_sync_reg[2];
    assign stop_det  =  scl_high &  sda_sync_reg[1] & ~sda_sync_reg[2];

    // ---------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------
    state_t           state_reg;
    logic [3:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             sda_oe_reg;
    logic             addr_match_reg;
    logic             data_acked_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [7:0]       staging_reg [NUM_DIGITS];
    logic [7:0]       display_reg [NUM_DIGITS];

`ifdef FND_SLAVE_READBACK_EN
    logic             rw_reg;
    logic [7:0]       tx_shift_reg;
    logic             master_nack_reg;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_DIGITS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic addr_hit;
    logic rw_accept;

    assign addr_hit = (shift_reg[7:1] == SLAVE_ADDR);
`ifdef FND_SLAVE_READBACK_EN
    assign rw_accept = 1'b1;
`else
    assign rw_accept = ~shift_reg[0];
`endif

    // STOP outranks START, and both outrank any SCL edge in the same clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            sda_oe_reg     <= 1'b0;
            addr_match_reg <= 1'b0;
            data_acked_reg <= 1'b0;
            ptr_reg        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                staging_reg[i] <= FND_BLANK;
                display_reg[i] <= FND_BLANK;
            end
`ifdef FND_SLAVE_READBACK_EN
            rw_reg          <= 1'b0;
            tx_shift_reg    <= '0;
            master_nack_reg <= 1'b0;
`endif
        end else if (stop_det) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            sda_oe_reg     <= 1'b0;
            addr_match_reg <= 1'b0;
            data_acked_reg <= 1'b0;
            if (data_acked_reg) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    display_reg[i] <= staging_reg[i];
                end
            end
        end else if (start_det) begin
            // Fresh or repeated START: staging and ptr survive, but the
            // pending commit is dropped until new data bytes arrive.
            state_reg      <= RX_ADDR;
            bit_cnt_reg    <= '0;
            sda_oe_reg     <= 1'b0;
            addr_match_reg <= 1'b0;
            data_acked_reg <= 1'b0;
        end else if (scl_rise) begin
            case (state_reg)
                RX_ADDR, RX_PTR, RX_DATA: begin
                    shift_reg   <= {shift_reg[6:0], sda_bit};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
`ifdef FND_SLAVE_READBACK_EN
                TX_ACK: master_nack_reg <= sda_bit;
`endif
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_reg)
                RX_ADDR: begin
                    if (bit_cnt_reg == 4'd8) begin
                        bit_cnt_reg <= '0;
                        if (addr_hit && rw_accept) begin
                            state_reg      <= ADDR_ACK;
                            sda_oe_reg     <= 1'b1;
                            addr_match_reg <= 1'b1;
`ifdef FND_SLAVE_READBACK_EN
                            rw_reg         <= shift_reg[0];
`endif
                        end else begin
                            state_reg      <= WAIT_STOP;
                            sda_oe_reg     <= 1'b0;
                            addr_match_reg <= 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    sda_oe_reg  <= 1'b0;
                    bit_cnt_reg <= '0;
                    state_reg   <= RX_PTR;
`ifdef FND_SLAVE_READBACK_EN
                    // Same falling edge that ends the ACK puts the MSB out.
                    if (rw_reg) begin
                        state_reg    <= TX_DATA;
                        sda_oe_reg   <= ~display_reg[ptr_reg][7];
                        tx_shift_reg <= {display_reg[ptr_reg][6:0], 1'b0};
                        bit_cnt_reg  <= 4'd1;
                        ptr_reg      <= ptr_inc(ptr_reg);
                    end
`endif
                end
                RX_PTR: begin
                    if (bit_cnt_reg == 4'd8) begin
                        bit_cnt_reg <= '0;
                        if (shift_reg < NUM_DIG_B) begin
                            ptr_reg    <= shift_reg[PTR_W-1:0];
                            sda_oe_reg <= 1'b1;
                            state_reg  <= PTR_ACK;
                        end else begin
                            sda_oe_reg <= 1'b0;
                            state_reg  <= WAIT_STOP;
                        end
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_reg == 4'd8) begin
                        bit_cnt_reg            <= '0;
                        staging_reg[ptr_reg]   <= shift_reg;
                        ptr_reg                <= ptr_inc(ptr_reg);
                        data_acked_reg         <= 1'b1;
                        sda_oe_reg             <= 1'b1;
                        state_reg              <= DATA_ACK;
                    end
                end
                PTR_ACK, DATA_ACK: begin
                    sda_oe_reg  <= 1'b0;
                    bit_cnt_reg <= '0;
                    state_reg   <= RX_DATA;
                end
`ifdef FND_SLAVE_READBACK_EN
                TX_DATA: begin
                    if (bit_cnt_reg == 4'd8) begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= TX_ACK;
                    end else begin
                        sda_oe_reg   <= ~tx_shift_reg[7];
                        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                    end
                end
                TX_ACK: begin
                    if (master_nack_reg) begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= WAIT_STOP;
                    end else begin
                        state_reg    <= TX_DATA;
                        sda_oe_reg   <= ~display_reg[ptr_reg][7];
                        tx_shift_reg <= {display_reg[ptr_reg][6:0], 1'b0};
                        bit_cnt_reg  <= 4'd1;
                        ptr_reg      <= ptr_inc(ptr_reg);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign sda              = sda_oe_reg ? 1'b0 : 1'bz;
    assign debug_addr_match = addr_match_reg;
    assign debug_state      = state_reg;

    fnd_scan_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .display (display_reg),
        .seg     (SEG),
        .an      (AN)
    );

endmodule

// File: tb/tb_i2c_fnd_mux_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_fnd_mux_slave
// Directed bench: a bit-banged I2C master drives the slave; expected segment
// patterns, ACKs and states are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_i2c_fnd_mux_slave;

    localparam int         NUM_DIGITS = 4;
    localparam int         SCAN_DIV   = 4;
    localparam int         Q          = 8;       // clks per quarter SCL phase
    localparam logic [6:0] SLAVE_ADDR = 7'h56;
    localparam logic [7:0] ADDR_W     = 8'hAC;
    localparam logic [7:0] ADDR_R     = 8'hAD;
    localparam logic [7:0] FOREIGN_W  = 8'hAE;

    localparam logic [6:0] S_BLANK = 7'h7F;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_2     = 7'b0100100;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_A     = 7'b0001000;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_F     = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic [6:0] seg;
    logic [3:0] an;
    logic       addr_match;
    logic [3:0] dstate;

    int checks   = 0;
    int failures = 0;
    int slave_drive_cnt = 0;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_fnd_mux_slave #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .scl              (scl),
        .sda              (sda),
        .SEG              (seg),
        .AN               (an),
        .debug_addr_match (addr_match),
        .debug_state      (dstate)
    );

    // Counts clks where the bus is low while the master is not pulling it.
    always @(negedge clk) begin
        if (!sda_low && sda === 1'b0) slave_drive_cnt++;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; clks(Q);
        scl = 1'b1;     clks(Q);
        sda_low = 1'b1; clks(Q);
        scl = 1'b0;     clks(Q);
        $display("i2c start");
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; clks(Q);
        scl = 1'b1;     clks(Q);
        sda_low = 1'b0; clks(Q);
        $display("i2c stop");
    endtask

    task automatic i2c_write(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i]; clks(Q);
            scl = 1'b1;      clks(Q);
            scl = 1'b0;      clks(Q);
        end
        sda_low = 1'b0; clks(Q);
        scl = 1'b1;     clks(Q / 2);
        ack = (sda === 1'b0);
        clks(Q / 2);
        scl = 1'b0;     clks(Q);
        $display("i2c write byte=%02h ack=%0b", b, ack);
    endtask

    task automatic i2c_read(input logic master_ack, output logic [7:0] b);
        sda_low = 1'b0;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            clks(Q);
            scl = 1'b1; clks(Q / 2);
            b[i] = (sda !== 1'b0);
            clks(Q / 2);
            scl = 1'b0;
        end
        sda_low = master_ack; clks(Q);
        scl = 1'b1;           clks(Q);
        scl = 1'b0;           clks(Q);
        sda_low = 1'b0;
        $display("i2c read byte=%02h master_ack=%0b", b, master_ack);
    endtask

    // Waits (bounded) for digit k's scan slot, then checks its anode and glyph.
    task automatic check_digit(input int k, input logic [6:0] exp_seg, input string tag);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << k);
        for (int i = 0; i < 64 && an !== exp_an; i++) @(negedge clk);
        chk({tag, "_an"}, 8'(an), 8'(exp_an));
        chk(tag, 8'(seg), 8'(exp_seg));
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         drive_before;

        // ---------------- reset state ----------------
        clks(5);
        chk("rst_seg",   8'(seg), 8'(S_BLANK));
        chk("rst_an",    8'(an), 8'(4'b1110));
        chk("rst_state", 8'(dstate), 8'd0);
        chk("rst_match", 8'(addr_match), 8'd0);
        chk("rst_sda",   8'(sda), 8'd1);
        rst = 1'b0;
        clks(3);

        // ---------------- basic write / commit ----------------
        i2c_start();
        i2c_write(ADDR_W, ack); chk("w1_addr_ack", 8'(ack), 8'd1);
        chk("w1_match", 8'(addr_match), 8'd1);
        chk("w1_state_ptr", 8'(dstate), 8'd3);
        i2c_write(8'h00, ack);  chk("w1_ptr_ack", 8'(ack), 8'd1);
        chk("w1_state_data", 8'(dstate), 8'd5);
        i2c_write(8'h01, ack);  chk("w1_d0_ack", 8'(ack), 8'd1);
        i2c_write(8'h02, ack);  chk("w1_d1_ack", 8'(ack), 8'd1);
        i2c_write(8'h03, ack);  chk("w1_d2_ack", 8'(ack), 8'd1);
        i2c_write(8'h04, ack);  chk("w1_d3_ack", 8'(ack), 8'd1);
        check_digit(0, S_BLANK, "w1_pre_d0");
        check_digit(3, S_BLANK, "w1_pre_d3");
        i2c_stop();
        chk("w1_idle", 8'(dstate), 8'd0);
        chk("w1_match_clr", 8'(addr_match), 8'd0);
        check_digit(0, S_1, "w1_d0");
        clks(SCAN_DIV);
        chk("w1_an1", 8'(an), 8'(4'b1101)); chk("w1_seg1", 8'(seg), 8'(S_2));
        clks(SCAN_DIV);
        chk("w1_an2", 8'(an), 8'(4'b1011)); chk("w1_seg2", 8'(seg), 8'(S_3));
        clks(SCAN_DIV);
        chk("w1_an3", 8'(an), 8'(4'b0111)); chk("w1_seg3", 8'(seg), 8'(S_4));

        // ---------------- wrap and blank ----------------
        i2c_start();
        i2c_write(ADDR_W, ack); chk("w2_addr_ack", 8'(ack), 8'd1);
        i2c_write(8'h03, ack);  chk("w2_ptr_ack", 8'(ack), 8'd1);
        i2c_write(8'h0A, ack);  chk("w2_d3_ack", 8'(ack), 8'd1);
        i2c_write(8'h80, ack);  chk("w2_d0_ack", 8'(ack), 8'd1);
        i2c_stop();
        check_digit(3, S_A, "w2_d3");
        check_digit(0, S_BLANK, "w2_d0");
        check_digit(1, S_2, "w2_d1");

        // ---------------- bad pointer ----------------
        i2c_start();
        i2c_write(ADDR_W, ack); chk("bp_addr_ack", 8'(ack), 8'd1);
        i2c_write(8'h04, ack);  chk("bp_ptr_nack", 8'(ack), 8'd0);
        chk("bp_wait_stop", 8'(dstate), 8'd9);
        i2c_write(8'h05, ack);  chk("bp_data_nack", 8'(ack), 8'd0);
        i2c_stop();
        check_digit(1, S_2, "bp_d1");
        check_digit(3, S_A, "bp_d3");

        // ---------------- foreign address ----------------
        drive_before = slave_drive_cnt;
        i2c_start();
        i2c_write(FOREIGN_W, ack); chk("fa_nack", 8'(ack), 8'd0);
        chk("fa_match", 8'(addr_match), 8'd0);
        i2c_write(8'h00, ack);     chk("fa_ptr_nack", 8'(ack), 8'd0);
        i2c_write(8'h07, ack);     chk("fa_data_nack", 8'(ack), 8'd0);
        i2c_stop();
        chk("fa_never_driven", 8'(slave_drive_cnt - drive_before), 8'd0);
        check_digit(2, S_3, "fa_d2");

        // ---------------- repeated START aborts commit ----------------
        i2c_start();
        i2c_write(ADDR_W, ack); chk("rs_addr_ack", 8'(ack), 8'd1);
        i2c_write(8'h00, ack);  chk("rs_ptr_ack", 8'(ack), 8'd1);
        i2c_write(8'h05, ack);  chk("rs_d0_ack", 8'(ack), 8'd1);
        i2c_start();
        chk("rs_state", 8'(dstate), 8'd1);
        i2c_write(ADDR_W, ack); chk("rs_addr2_ack", 8'(ack), 8'd1);
        i2c_write(8'h01, ack);  chk("rs_ptr2_ack", 8'(ack), 8'd1);
        i2c_stop();
        check_digit(0, S_BLANK, "rs_d0");
        check_digit(1, S_2, "rs_d1");

        // ---------------- readback ----------------
`ifdef FND_SLAVE_READBACK_EN
        i2c_start();
        i2c_write(ADDR_W, ack); chk("rb_addr_ack", 8'(ack), 8'd1);
        i2c_write(8'h01, ack);  chk("rb_ptr_ack", 8'(ack), 8'd1);
        i2c_start();
        i2c_write(ADDR_R, ack); chk("rb_raddr_ack", 8'(ack), 8'd1);
        i2c_read(1'b1, rd);     chk("rb_byte1", rd, 8'h02);
        i2c_read(1'b0, rd);     chk("rb_byte2", rd, 8'h03);
        chk("rb_released", 8'(sda), 8'd1);
        chk("rb_wait_stop", 8'(dstate), 8'd9);
        i2c_stop();
`else
        i2c_start();
        i2c_write(ADDR_R, ack); chk("rb_raddr_nack", 8'(ack), 8'd0);
        chk("rb_match", 8'(addr_match), 8'd0);
        chk("rb_wait_stop", 8'(dstate), 8'd9);
        rd = 8'h00;
        i2c_stop();
`endif
        check_digit(1, S_2, "rb_d1");

        // ---------------- reset mid-transaction ----------------
        i2c_start();
        i2c_write(ADDR_W, ack); chk("mr_addr_ack", 8'(ack), 8'd1);
        i2c_write(8'h00, ack);  chk("mr_ptr_ack", 8'(ack), 8'd1);
        chk("mr_in_rx_data", 8'(dstate), 8'd5);
        rst = 1'b1;
        clks(1);
        chk("mr_sda", 8'(sda), 8'd1);
        chk("mr_state", 8'(dstate), 8'd0);
        chk("mr_an", 8'(an), 8'(4'b1110));
        chk("mr_seg", 8'(seg), 8'(S_BLANK));
        clks(2);
        rst = 1'b0;
        check_digit(1, S_BLANK, "mr_d1");
        check_digit(3, S_BLANK, "mr_d3");

        i2c_start();
        i2c_write(ADDR_W, ack); chk("pr_addr_ack", 8'(ack), 8'd1);
        i2c_write(8'h02, ack);  chk("pr_ptr_ack", 8'(ack), 8'd1);
        i2c_write(8'h0E, ack);  chk("pr_d2_ack", 8'(ack), 8'd1);
        i2c_write(8'h0F, ack);  chk("pr_d3_ack", 8'(ack), 8'd1);
        i2c_stop();
        check_digit(2, S_E, "pr_d2");
        check_digit(3, S_F, "pr_d3");
        check_digit(0, S_BLANK, "pr_d0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
